// File: rtl/stopwatch_ctrl.sv
// Stopwatch control stage feeding the cascaded BCD digit counters.
// Synchronizes and debounces the start/clear buttons, turns each debounced
// press into a one-cycle pulse, runs the IDLE/RUN/PAUSE machine and produces
// the counters' count-enable tick and active-low clear.
//
// Ports:
//   clk        system clock, all state on the rising edge
//   rst        asynchronous active-high reset
//   btn_start  raw start/pause button (asynchronous, active-high)
//   btn_clear  raw clear button (asynchronous, active-high)
//   cnt_en     one-cycle count-enable pulse to the digit counters
//   cnt_clr_n  active-low clear to the digit counters
//   running    high while in RUN
//   paused     high while in PAUSE
module stopwatch_ctrl #(
  parameter int unsigned TICK_DIV  = 100000000,
  parameter int unsigned DB_CYCLES = 1000000,
  parameter int unsigned DIV_W     = 27,
  parameter int unsigned DB_W      = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_start,
  input  logic btn_clear,
  output logic cnt_en,
  output logic cnt_clr_n,
  output logic running,
  output logic paused
);

  localparam int unsigned NBTN    = 2;
  localparam int unsigned BTN_STA = 0;
  localparam int unsigned BTN_CLR = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [NBTN-1:0]           sync1_q, sync2_q;
  logic [NBTN-1:0]           lvl_q, lvl_d, lvl_prev_q;
  logic [NBTN-1:0][DB_W-1:0] db_cnt_q, db_cnt_d;
  logic [DIV_W-1:0]          div_q, div_d;
  logic                      cnt_en_q, cnt_en_d;
  logic                      clr_n_q, clr_n_d;
  logic                      running_q, running_d;
  logic                      paused_q, paused_d;
  logic                      start_p, clear_p;

  // Two-flop synchronizers, debounce counters and edge-detect history.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      lvl_q      <= '0;
      lvl_prev_q <= '0;
      db_cnt_q   <= '0;
    end else begin
      sync1_q    <= {btn_clear, btn_start};
      sync2_q    <= sync1_q;
      lvl_q      <= lvl_d;
      lvl_prev_q <= lvl_q;
      db_cnt_q   <= db_cnt_d;
    end
  end

  // Debounce: the level only follows the sample after DB_CYCLES consecutive
  // disagreeing samples; any agreeing sample restarts the count.
  always_comb begin
    lvl_d    = lvl_q;
    db_cnt_d = '0;
    for (int i = 0; i < NBTN; i++) begin
      if (sync2_q[i] != lvl_q[i]) begin
        if (db_cnt_q[i] == DB_W'(DB_CYCLES - 1)) begin
          lvl_d[i] = sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
        end
      end
    end
  end

  // Press pulses: rising edge of the debounced level only.
  assign start_p = lvl_q[BTN_STA] & ~lvl_prev_q[BTN_STA];
  assign clear_p = lvl_q[BTN_CLR] & ~lvl_prev_q[BTN_CLR];

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; clear overrides a simultaneous start.
  always_comb begin
    state_d = state_q;
    if (clear_p) begin
      state_d = IDLE;
    end else if (start_p) begin
      case (state_q)
        IDLE:    state_d = RUN;
        RUN:     state_d = PAUSE;
        PAUSE:   state_d = RUN;
        default: state_d = IDLE;
      endcase
    end
  end

  // Output/divider next values. The divider advances only while RUN persists
  // across the edge, so it freezes in PAUSE and never ticks on a RUN exit.
  always_comb begin
    div_d     = div_q;
    cnt_en_d  = 1'b0;
    clr_n_d   = ~clear_p;
    running_d = (state_d == RUN);
    paused_d  = (state_d == PAUSE);
    if (state_d == IDLE) begin
      div_d = '0;
    end else if ((state_q == RUN) && (state_d == RUN)) begin
      if (div_q == DIV_W'(TICK_DIV - 1)) begin
        div_d    = '0;
        cnt_en_d = 1'b1;
      end else begin
        div_d = div_q + DIV_W'(1);
      end
    end
  end

  // Output and divider registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q     <= '0;
      cnt_en_q  <= 1'b0;
      clr_n_q   <= 1'b0;
      running_q <= 1'b0;
      paused_q  <= 1'b0;
    end else begin
      div_q     <= div_d;
      cnt_en_q  <= cnt_en_d;
      clr_n_q   <= clr_n_d;
      running_q <= running_d;
      paused_q  <= paused_d;
    end
  end

  assign cnt_en    = cnt_en_q;
  assign cnt_clr_n = clr_n_q;
  assign running   = running_q;
  assign paused    = paused_q;

endmodule
